// File: rtl/risc_pkg.sv
// Shared constants and types for the risc core memory subsystem.
package risc_pkg;

    localparam int unsigned RISC_AWIDTH = 5;
    localparam int unsigned RISC_DWIDTH = 8;

    typedef enum logic [1:0] {
        ARB_CPU   = 2'd0,
        ARB_DRAIN = 2'd1,
        ARB_HOST  = 2'd2
    } arb_state_t;

    // Bits needed to hold values 0..maxval.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/arb_guard_counter.sv
// Loadable down-counter that saturates at zero; times the post-burst cooldown.
module arb_guard_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/counter.sv
// Generic up-counter with synchronous load; load takes priority over count.
module counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= din;
        end else if (enab) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_host_arbiter.sv
// Shares the core memory between the CPU and a host port; host bursts start only
// at an instruction boundary (phase 0, counter frozen) or while the CPU is halted.
module mem_host_arbiter
    import risc_pkg::*;
#(
    parameter int unsigned AWIDTH    = RISC_AWIDTH,
    parameter int unsigned DWIDTH    = RISC_DWIDTH,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned COOLDOWN  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cpu_phase,
    input  logic              cpu_halt,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_data_e,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_last,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    input  logic [DWIDTH-1:0] mem_data_in,
    output logic              host_gnt,
    output logic              host_ack,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              cpu_stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_wdata_en,
    output logic              mem_cpu_drive
);

    localparam int unsigned BW = cnt_width(MAX_BURST);
    localparam int unsigned GW = cnt_width(COOLDOWN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(COOLDOWN);

    arb_state_t        state_q, state_d;
    logic              gnt_q;
    logic [DWIDTH-1:0] rdata_q;
    logic [BW-1:0]     beat_cnt;
    logic [GW-1:0]     guard;
    logic              guard_zero;
    logic              burst_exit;

    assign guard_zero = (guard == '0);

    counter #(
        .WIDTH (BW)
    ) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (burst_exit),
        .enab (host_ack),
        .din  ('0),
        .cnt  (beat_cnt)
    );

    // The phase counter only advances while the CPU is neither halted nor stalled.
    arb_guard_counter #(
        .WIDTH (GW)
    ) u_guard (
        .clk      (clk),
        .rst      (rst),
        .load     (burst_exit),
        .load_val (GUARD_LOAD),
        .dec      (!cpu_halt && (state_q != ARB_HOST)),
        .cnt      (guard)
    );

    always_comb begin
        state_d       = state_q;
        burst_exit    = 1'b0;
        host_ack      = 1'b0;
        mem_rd        = cpu_rd;
        mem_wr        = cpu_wr;
        mem_addr      = cpu_addr;
        mem_cpu_drive = cpu_data_e;
        mem_wdata_en  = 1'b0;
        mem_wdata     = '0;
        unique case (state_q)
            ARB_CPU: begin
                if (host_req && (guard_zero || cpu_halt)) begin
                    state_d = cpu_halt ? ARB_HOST : ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                // Leaving on phase 7 lets the counter wrap to 0 before it freezes.
                if ((cpu_phase == 3'd7) || cpu_halt) begin
                    state_d = ARB_HOST;
                end
            end
            ARB_HOST: begin
                host_ack      = host_req;
                mem_addr      = host_addr;
                mem_cpu_drive = 1'b0;
                mem_rd        = host_req && !host_we;
                mem_wr        = host_req && host_we;
                mem_wdata_en  = host_req && host_we;
                mem_wdata     = (host_req && host_we) ? host_wdata : '0;
                if (!host_req || host_last || (beat_cnt == LAST_BEAT)) begin
                    burst_exit = 1'b1;
                    state_d    = ARB_CPU;
                end
            end
            default: state_d = ARB_CPU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_CPU;
            gnt_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= (state_d == ARB_HOST);
            if ((state_q == ARB_HOST) && host_req && !host_we) begin
                rdata_q <= mem_data_in;
            end
        end
    end

    assign host_gnt   = gnt_q;
    assign cpu_stall  = gnt_q;
    assign host_rdata = rdata_q;

endmodule

// File: tb/tb_mem_host_arbiter.sv
// Directed bench for mem_host_arbiter with a phase counter and memory around it.
module tb_mem_host_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] phase;
    logic       cpu_halt, cpu_rd, cpu_wr, cpu_data_e;
    logic [4:0] cpu_addr;
    logic       host_req, host_we, host_last;
    logic [4:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] mem_data_in;
    logic       host_gnt, host_ack, cpu_stall;
    logic [7:0] host_rdata;
    logic       mem_rd, mem_wr, mem_wdata_en, mem_cpu_drive;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem [32];
    logic [7:0] bus;
    logic [7:0] rd_exp [4];
    int         n_cmp = 0;
    int         n_err = 0;
    int         t;

    always #5 clk = ~clk;

    mem_host_arbiter #(
        .AWIDTH    (5),
        .DWIDTH    (8),
        .MAX_BURST (4),
        .COOLDOWN  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_phase     (phase),
        .cpu_halt      (cpu_halt),
        .cpu_rd        (cpu_rd),
        .cpu_wr        (cpu_wr),
        .cpu_data_e    (cpu_data_e),
        .cpu_addr      (cpu_addr),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_last     (host_last),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .mem_data_in   (mem_data_in),
        .host_gnt      (host_gnt),
        .host_ack      (host_ack),
        .host_rdata    (host_rdata),
        .cpu_stall     (cpu_stall),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wdata_en  (mem_wdata_en),
        .mem_cpu_drive (mem_cpu_drive)
    );

    // Phase counter enable as wired in the core: !halt && !stall.
    always @(posedge clk) begin
        if (rst) phase <= 3'd0;
        else if (!cpu_halt && !cpu_stall) phase <= phase + 3'd1;
    end

    assign bus         = mem_wdata_en ? mem_wdata : (mem_cpu_drive ? 8'hEE : 8'h00);
    assign mem_data_in = mem_rd ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h10 + 8'(i);
        end else if (mem_wr) begin
            mem[mem_addr] <= bus;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu_halt = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_data_e = 1'b0; cpu_addr = 5'd0;
        host_req = 1'b0; host_we = 1'b0; host_last = 1'b0; host_addr = 5'd0; host_wdata = 8'd0;
        rd_exp[0] = 8'h10; rd_exp[1] = 8'h11; rd_exp[2] = 8'h12; rd_exp[3] = 8'hA5;

        // Reset state and CPU pass-through
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_gnt", 32'(host_gnt), 0);
        check("rst_stall", 32'(cpu_stall), 0);
        check("rst_ack", 32'(host_ack), 0);
        check("rst_rdata", 32'(host_rdata), 0);
        check("rst_guard", 32'(dut.guard), 0);
        check("rst_wdata_en", 32'(mem_wdata_en), 0);
        cpu_rd = 1'b1; cpu_addr = 5'd7; cpu_data_e = 1'b1; #1;
        check("pt_rd", 32'(mem_rd), 1);
        check("pt_addr", 32'(mem_addr), 7);
        check("pt_drive", 32'(mem_cpu_drive), 1);
        @(negedge clk);
        rst = 1'b0; cpu_rd = 1'b0; cpu_addr = 5'd0; cpu_data_e = 1'b0;

        // Write beat requested at phase 2 waits for the phase 7 -> 0 edge
        @(negedge clk);
        @(negedge clk); #1;
        check("t1_start_phase", 32'(phase), 2);
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'h03; host_wdata = 8'hA5; host_last = 1'b1;
        #1;
        check("t1_req_ack", 32'(host_ack), 0);
        for (int p = 3; p <= 7; p++) begin
            @(negedge clk); #1;
            check("t1_drain_phase", 32'(phase), 32'(p));
            check("t1_drain_ack", 32'(host_ack), 0);
            check("t1_drain_gnt", 32'(host_gnt), 0);
        end
        @(negedge clk); #1;
        check("t1_gnt", 32'(host_gnt), 1);
        check("t1_stall", 32'(cpu_stall), 1);
        check("t1_phase0", 32'(phase), 0);
        check("t1_ack", 32'(host_ack), 1);
        check("t1_mem_wr", 32'(mem_wr), 1);
        check("t1_mem_rd", 32'(mem_rd), 0);
        check("t1_mem_addr", 32'(mem_addr), 3);
        check("t1_wdata_en", 32'(mem_wdata_en), 1);
        check("t1_wdata", 32'(mem_wdata), 32'hA5);
        @(negedge clk);
        host_req = 1'b0; host_we = 1'b0; host_last = 1'b0; #1;
        check("t1_resume_gnt", 32'(host_gnt), 0);
        check("t1_resume_stall", 32'(cpu_stall), 0);
        check("t1_resume_phase", 32'(phase), 0);
        check("t1_mem3", 32'(mem[3]), 32'hA5);
        check("t1_guard", 32'(dut.guard), 8);

        // Halted read burst of 4 beats bypasses the cooldown
        @(negedge clk);
        cpu_halt = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 5'd0; host_last = 1'b0;
        #1;
        check("t2_req_gnt", 32'(host_gnt), 0);
        check("t2_req_ack", 32'(host_ack), 0);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            host_addr = 5'(n); host_last = (n == 3); #1;
            check("t2_gnt", 32'(host_gnt), 1);
            check("t2_ack", 32'(host_ack), 1);
            check("t2_mem_rd", 32'(mem_rd), 1);
            check("t2_mem_addr", 32'(mem_addr), 32'(n));
            if (n > 0) check("t2_rdata", 32'(host_rdata), 32'(rd_exp[n-1]));
        end
        @(negedge clk);
        host_req = 1'b0; host_last = 1'b0; #1;
        check("t2_rdata_last", 32'(host_rdata), 32'hA5);
        check("t2_end_gnt", 32'(host_gnt), 0);
        check("t2_guard", 32'(dut.guard), 8);

        // Six-beat write request, CPU running: truncated at 4, then cooldown + drain
        @(negedge clk);
        cpu_halt = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 5'd8;
        host_wdata = 8'hC0; host_last = 1'b0;
        #1;
        t = 0;
        while (host_gnt !== 1'b1 && t < 40) begin
            @(negedge clk); #1;
            t++;
        end
        check("t3_first_gnt", 32'(host_gnt), 1);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                @(negedge clk);
                host_addr = 5'(8 + b); host_wdata = 8'hC0 + 8'(b); #1;
            end
            check("t3_ack", 32'(host_ack), 1);
            check("t3_mem_wr", 32'(mem_wr), 1);
            check("t3_mem_addr", 32'(mem_addr), 32'(8 + b));
        end
        @(negedge clk);
        host_addr = 5'd12; host_wdata = 8'hC4; #1;
        check("t3_trunc_gnt", 32'(host_gnt), 0);
        check("t3_trunc_ack", 32'(host_ack), 0);
        check("t3_trunc_stall", 32'(cpu_stall), 0);
        check("t3_trunc_guard", 32'(dut.guard), 8);
        t = 0;
        while (host_gnt !== 1'b1 && t < 40) begin
            @(negedge clk); #1;
            t++;
        end
        check("t3_regrant_cycles", 32'(t), 16);

        // CPU write and bus drive blocked while the host owns memory
        cpu_wr = 1'b1; cpu_data_e = 1'b1; cpu_addr = 5'h1F; #1;
        check("t4_drive", 32'(mem_cpu_drive), 0);
        check("t4_mem_wr", 32'(mem_wr), 1);
        check("t4_mem_addr", 32'(mem_addr), 12);
        check("t4_ack", 32'(host_ack), 1);
        @(negedge clk);
        host_we = 1'b0; host_addr = 5'd8; host_last = 1'b1; #1;
        check("t4_rd_mem_wr", 32'(mem_wr), 0);
        check("t4_rd_mem_rd", 32'(mem_rd), 1);
        check("t4_rd_drive", 32'(mem_cpu_drive), 0);
        @(negedge clk);
        cpu_wr = 1'b0; cpu_data_e = 1'b0; cpu_addr = 5'd0;
        host_req = 1'b0; host_last = 1'b0; #1;
        check("t4_end_gnt", 32'(host_gnt), 0);
        check("t4_rdata", 32'(host_rdata), 32'hC0);
        check("t4_mem11", 32'(mem[11]), 32'hC3);
        check("t4_mem12", 32'(mem[12]), 32'hC4);

        // Reset during beat 2 of a write burst
        @(negedge clk);
        cpu_halt = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 5'd20; host_wdata = 8'h5A;
        #1;
        check("t5_req_gnt", 32'(host_gnt), 0);
        @(negedge clk); #1;
        check("t5_beat1_ack", 32'(host_ack), 1);
        @(negedge clk);
        host_addr = 5'd21; host_wdata = 8'h5B; rst = 1'b1; #1;
        check("t5_beat2_ack", 32'(host_ack), 1);
        @(negedge clk);
        rst = 1'b0; host_req = 1'b0; cpu_halt = 1'b0; host_we = 1'b0; #1;
        check("t5_gnt", 32'(host_gnt), 0);
        check("t5_stall", 32'(cpu_stall), 0);
        check("t5_ack", 32'(host_ack), 0);
        check("t5_guard", 32'(dut.guard), 0);
        check("t5_rdata", 32'(host_rdata), 0);

        // Request dropped for one cycle mid-burst ends the burst
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd16; host_wdata = 8'h77; host_last = 1'b0;
        #1;
        t = 0;
        while (host_gnt !== 1'b1 && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        check("t6_gnt", 32'(host_gnt), 1);
        check("t6_ack", 32'(host_ack), 1);
        @(negedge clk);
        host_req = 1'b0; #1;
        check("t6_gap_ack", 32'(host_ack), 0);
        check("t6_gap_mem_wr", 32'(mem_wr), 0);
        check("t6_gap_gnt", 32'(host_gnt), 1);
        @(negedge clk);
        host_req = 1'b1; #1;
        check("t6_exit_gnt", 32'(host_gnt), 0);
        check("t6_exit_stall", 32'(cpu_stall), 0);
        check("t6_exit_guard", 32'(dut.guard), 8);
        check("t6_exit_ack", 32'(host_ack), 0);
        check("t6_mem16", 32'(mem[16]), 32'h77);
        @(negedge clk);
        host_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_host_arbiter.md
Name: mem_host_arbiter

Overview:
Shares the single data/program memory of the risc core between the CPU and an external host loader/debug port.
- Host accesses are only granted at instruction boundaries, at phase 0 with the phase counter frozen.
- Grants are bursts of at most MAX_BURST beats.
- A cooldown guarantees the CPU completes at least one instruction between bursts.
- Sits between the Controller/PC mux and the memory; its cpu_stall output gates the phase counter enable (enab = !halt && !cpu_stall).

Parameters:
AWIDTH, 5, memory address width
DWIDTH, 8, memory data width
MAX_BURST, 4, max host beats per grant (1..2**BW-1)
COOLDOWN, 8, CPU phase advances required after a burst before the next grant

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_phase  in  3  phase counter output
cpu_halt  in  1  Controller halt
cpu_rd  in  1  Controller rd
cpu_wr  in  1  Controller wr
cpu_data_e  in  1  Controller data_e
cpu_addr  in  AWIDTH  address-mux output
host_req  in  1  host requests a beat this cycle
host_we  in  1  beat is a write
host_last  in  1  final beat of burst
host_addr  in  AWIDTH  host beat address
host_wdata  in  DWIDTH  host write data
mem_data_in  in  DWIDTH  memory data bus sample
host_gnt  out  1  host owns memory
host_ack  out  1  beat performed this cycle
host_rdata  out  DWIDTH  registered read data
cpu_stall  out  1  freezes phase counter
mem_rd  out  1  memory rd
mem_wr  out  1  memory wr
mem_addr  out  AWIDTH  memory address
mem_wdata  out  DWIDTH  host data onto bus
mem_wdata_en  out  1  host bus driver enable
mem_cpu_drive  out  1  gated CPU data_e to CPU bus driver

Behaviour:
- States: CPU, DRAIN, HOST. Reset -> CPU, beat_cnt=0, guard=0, host_rdata=0. All outputs are 0 during and after reset, except pass-through CPU controls.
- CPU: memory controls pass through (mem_rd=cpu_rd, mem_wr=cpu_wr, mem_addr=cpu_addr, mem_cpu_drive=cpu_data_e).
  - guard decrements (saturating at 0) on every cycle the CPU is not halted.
  - If host_req and (guard==0 or cpu_halt): go to HOST when cpu_halt; go to DRAIN otherwise.
- DRAIN: CPU keeps running with pass-through controls. In the cycle with cpu_phase==7 go to HOST, so the phase counter lands on 0. If cpu_halt rises in DRAIN, go to HOST next cycle.
- HOST:
  - cpu_stall=1, host_gnt=1. cpu_rd, cpu_wr, cpu_data_e are blocked; mem_addr=host_addr.
  - host_ack = host_req (combinational).
  - On ack: mem_wr=host_we; mem_wdata_en=host_we; mem_rd=!host_we.
  - On a read ack, host_rdata <= mem_data_in; valid the cycle after ack and held until the next read ack.
  - beat_cnt increments per ack.
  - Exit to CPU after the clock edge of the ack with host_last, the ack where beat_cnt+1==MAX_BURST, or any HOST cycle with host_req=0 (zero-beat exit). On exit: beat_cnt=0, guard=COOLDOWN.
- cpu_stall, host_gnt and state are registered. host_ack, mem_* are combinational from state and inputs.
- MAX_BURST reached with host_last=0: burst truncated. Host must re-request and waits out the cooldown unless cpu_halt.
- host_req while guard>0 and CPU running: ignored (no gnt, no ack) until guard==0.
- cpu_halt: guard is bypassed, so unlimited back-to-back bursts are allowed.
- rst mid-burst: burst aborted, next cycle CPU state, host_ack=0, cpu_stall=0.
- The CPU never sees a partial instruction: the stall is entered only at the phase 7->0 edge or while halted.

Decomposition:
- Shared package risc_pkg: AWIDTH/DWIDTH defaults and state encoding localparams (ARB_CPU=2'd0, ARB_DRAIN=2'd1, ARB_HOST=2'd2).
- One natural sub-module: arb_guard_counter. It is the loadable saturating down-counter for the cooldown.
- beat_cnt reuses the existing counter module (load=exit, enab=host_ack).

Test Plan:
- Reset then host_req=1, we=1, addr=5'h03, wdata=8'hA5, last=1, with CPU running at phase 2 -> no ack while phase 3..7; HOST on the edge after phase 7; phase stays 0; one ack with mem_wr=1, mem_addr=3; CPU resumes the next cycle; memory[3]=A5.
- Read burst addr 0,1,2,3 with last on beat 3, cpu_halt=1 -> gnt the cycle after req; 4 consecutive acks; host_rdata equals mem[n] one cycle after each ack; then CPU state.
- Burst of 6 beats, MAX_BURST=4, CPU running -> 4 acks then gnt drops; req held; no re-grant until 8 phase advances plus drain to phase 7 edge.
- host_req asserted during HOST with cpu_data_e=1, cpu_wr=1 -> mem_cpu_drive=0, mem_wr reflects host_we only.
- rst pulsed during beat 2 of a write burst -> next cycle host_gnt=0, cpu_stall=0, host_ack=0, guard=0, host_rdata=0.
- host_req dropped for one cycle mid-burst -> burst ends, guard loaded 8, cpu_stall=0 the next cycle.
